// File: rtl/maquina_pkg.sv
// maquina_pkg: shared definitions for the vending-machine transaction sequencer.
//   - estado_t   : FSM state encoding (ESPERA..TROCO); codes 5..7 are unused.
//   - moeda_unidades(code) : coin code -> value in coin units (1 unit = R$0.25).
//   - preco(id)  : 16-entry price table, id = {d1,d2}, price = 2 + d1 + d2 units.
//   - *_DEF      : default parameter values for maquina_controle.
package maquina_pkg;

  localparam int CREDIT_W_DEF   = 6;
  localparam int TIMEOUT_DEF    = 1000;
  localparam int INIT_STOCK_DEF = 3;
  localparam int PRECO_W        = 4;   // max price is 2+3+3 = 8

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    DIGITO2 = 3'd1,
    PAGA    = 3'd2,
    LIBERA  = 3'd3,
    TROCO   = 3'd4
  } estado_t;

  // Coin codes 0..3 are worth 1, 2, 4, 8 units.
  function automatic logic [3:0] moeda_unidades(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

  // Product id is the two captured digits; the price grows with both digits.
  function automatic logic [PRECO_W-1:0] preco(input logic [3:0] id);
    return 4'd2 + {2'b00, id[3:2]} + {2'b00, id[1:0]};
  endfunction

endpackage

// File: rtl/maquina_controle_detector_tecla.sv
// detector_tecla: keypad edge detector.
//   Registers the previous keypad value and flags a press only when the pad
//   was fully released in the previous cycle and exactly one key is down now.
//   Held keys and multi-key chords never produce a strobe.
// Ports:
//   clk, reset   : clock (rising edge), synchronous active-high reset
//   tecla [3:0]  : raw one-hot keypad
//   press        : one-cycle strobe for an accepted key
//   digito [1:0] : digit of the pressed key (key n -> n), valid with press
module detector_tecla (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] tecla,
  output logic       press,
  output logic [1:0] digito
);

  logic [3:0] tecla_ant;

  always_ff @(posedge clk) begin
    if (reset) tecla_ant <= 4'd0;
    else       tecla_ant <= tecla;
  end

  assign press = (tecla_ant == 4'd0) && $onehot(tecla);

  // Only meaningful for one-hot input; picks the highest set bit otherwise.
  always_comb begin
    digito = 2'd0;
    for (int i = 0; i < 4; i++)
      if (tecla[i]) digito = 2'(i);
  end

endmodule

// File: rtl/maquina_controle.sv
// maquina_controle: vending-machine transaction sequencer.
//   Captures a two-digit product code from the keypad, accumulates coins in
//   the credit register, pulses the dispenser, then returns any change.
//   An inactivity timer aborts abandoned transactions (refunding credit).
//
// Optional feature (macro ESTOQUE_EN): sixteen 2-bit stock counters, loaded
//   with INIT_STOCK on reset and decremented on each dispense; selecting an
//   empty product raises erro and returns to ESPERA. Without the macro stock
//   is unlimited.
//
// Ports:
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   tecla [3:0]         : one-hot keypad, key n gives digit n
//   moeda_valida        : one-cycle coin strobe, moeda_valor: 0/1/2/3 = 1/2/4/8 units
//   cancela             : cancel button (level)
//   digito [1:0]        : digit expected next (1, 2, 0 = none)
//   produto [3:0]       : captured code {d1,d2}
//   credito             : current credit in coin units
//   libera              : one-cycle dispense pulse
//   troco_valido, troco : one-cycle change strobe and amount
//   moeda_rejeita       : one-cycle coin-returned pulse
//   erro                : one-cycle abort / empty-product pulse
//   estado [2:0]        : current FSM state code
module maquina_controle
  import maquina_pkg::*;
#(
  parameter int CREDIT_W       = CREDIT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int INIT_STOCK     = INIT_STOCK_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          tecla,
  input  logic                moeda_valida,
  input  logic [1:0]          moeda_valor,
  input  logic                cancela,
  output logic [1:0]          digito,
  output logic [3:0]          produto,
  output logic [CREDIT_W-1:0] credito,
  output logic                libera,
  output logic                troco_valido,
  output logic [CREDIT_W-1:0] troco,
  output logic                moeda_rejeita,
  output logic                erro,
  output logic [2:0]          estado
);

  localparam int SOMA_W  = CREDIT_W + 1;
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_FIM = TIMER_W'(TIMEOUT_CYCLES - 1);

  estado_t              st;
  logic [1:0]           d1;
  logic [TIMER_W-1:0]   timer;
  logic                 press;
  logic [1:0]           dig;
  logic [SOMA_W-1:0]    soma;
  logic [SOMA_W-1:0]    preco_atual;
  logic [CREDIT_W-1:0]  resto;
  logic                 coin_ok;
  logic                 pago;
  logic                 timeout;
  logic                 sem_estoque;

  detector_tecla u_det (
    .clk    (clk),
    .reset  (reset),
    .tecla  (tecla),
    .press  (press),
    .digito (dig)
  );

  // One extra bit on the sum exposes credit overflow; an overflowing coin is
  // returned rather than wrapping the credit register.
  assign soma        = {1'b0, credito} + SOMA_W'(moeda_unidades(moeda_valor));
  assign preco_atual = SOMA_W'(preco(produto));
  assign resto       = credito - preco_atual[CREDIT_W-1:0];
  assign coin_ok     = moeda_valida && (st == PAGA) && !soma[CREDIT_W];
  assign pago        = coin_ok && (soma >= preco_atual);
  assign timeout     = (timer == TIMER_FIM);
  assign estado      = st;

`ifdef ESTOQUE_EN
  logic [1:0] estoque [16];
  // Checked against the digit being pressed now, before produto is latched.
  assign sem_estoque = (estoque[{d1, dig}] == 2'd0);
`else
  assign sem_estoque = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= ESPERA;
      digito        <= 2'd1;
      produto       <= 4'd0;
      credito       <= '0;
      libera        <= 1'b0;
      troco_valido  <= 1'b0;
      troco         <= '0;
      moeda_rejeita <= 1'b0;
      erro          <= 1'b0;
      timer         <= '0;
      d1            <= 2'd0;
`ifdef ESTOQUE_EN
      for (int i = 0; i < 16; i++) estoque[i] <= 2'(INIT_STOCK);
`endif
    end else begin
      libera        <= 1'b0;
      troco_valido  <= 1'b0;
      erro          <= 1'b0;
      moeda_rejeita <= 1'b0;
      timer         <= timer + TIMER_W'(1);

      // Any coin not accepted into PAGA (wrong state or overflow) goes back.
      if (moeda_valida && !coin_ok) moeda_rejeita <= 1'b1;

      case (st)
        ESPERA: begin
          timer <= '0;
          if (press) begin
            d1     <= dig;
            st     <= DIGITO2;
            digito <= 2'd2;
          end
        end

        DIGITO2: begin
          if (press) begin
            timer   <= '0;
            produto <= {d1, dig};
            if (sem_estoque) begin
              erro   <= 1'b1;
              st     <= ESPERA;
              digito <= 2'd1;
            end else begin
              st     <= PAGA;
              digito <= 2'd0;
            end
          end else if (cancela) begin
            st     <= ESPERA;
            digito <= 2'd1;
          end else if (timeout) begin
            erro   <= 1'b1;
            st     <= ESPERA;
            digito <= 2'd1;
          end
        end

        PAGA: begin
          if (coin_ok) begin
            credito <= soma[CREDIT_W-1:0];
            timer   <= '0;
          end
          // Completed payment beats a simultaneous cancel; a coin arriving
          // with cancel is still credited and so lands in the refund.
          if (pago) begin
            st     <= LIBERA;
            libera <= 1'b1;
          end else if (cancela || (!coin_ok && timeout)) begin
            st           <= TROCO;
            troco_valido <= coin_ok ? (soma[CREDIT_W-1:0] != '0) : (credito != '0);
            troco        <= coin_ok ? soma[CREDIT_W-1:0] : credito;
            if (!cancela) erro <= 1'b1;
          end
        end

        LIBERA: begin
          // Change strobe is registered on the way into TROCO so it shows
          // two cycles after the final coin.
          credito      <= resto;
          troco_valido <= (resto != '0);
          troco        <= resto;
          st           <= TROCO;
`ifdef ESTOQUE_EN
          estoque[produto] <= estoque[produto] - 2'd1;
`endif
        end

        TROCO: begin
          credito <= '0;
          st      <= ESPERA;
          digito  <= 2'd1;
        end

        default: begin
          st     <= ESPERA;
          digito <= 2'd1;
        end
      endcase
    end
  end

endmodule

// File: doc/maquina_controle.md
Name: maquina_controle

Overview:
- Transaction sequencer for the vending machine.
- Captures a two-key product code from the 4-key keypad, accepts coins, dispenses, then returns change.
- Sits between the keypad/coin acceptor inputs and the dispenser/display outputs, and owns the credit register and the inactivity timeout.

Parameters:
- CREDIT_W, 6, credit/change width in coin units (1 unit = R$0.25).
- TIMEOUT_CYCLES, 1000, idle cycles before an abandoned transaction is aborted.
- INIT_STOCK, 3, initial per-product stock (used only with ESTOQUE_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- tecla  in  4  keypad, one-hot; key n gives digit n.
- moeda_valida  in  1  one-cycle coin-inserted strobe.
- moeda_valor  in  2  coin code: 0=1, 1=2, 2=4, 3=8 units.
- cancela  in  1  cancel button, level.
- digito  out  2  expected digit for display: 1, 2, 0=none.
- produto  out  4  captured code {d1,d2}.
- credito  out  CREDIT_W  current credit.
- libera  out  1  one-cycle dispense pulse.
- troco_valido  out  1  one-cycle change strobe.
- troco  out  CREDIT_W  change amount; valid with troco_valido.
- moeda_rejeita  out  1  one-cycle coin-returned pulse.
- erro  out  1  one-cycle pulse on abort or empty product.
- estado  out  3  current FSM state code.

Behaviour:
- Reset: all outputs 0 except digito=1; state ESPERA; credito=0; timer=0; tecla history=0. Reset mid-transaction discards credit with no troco pulse.
- Key press: accepted only when the registered previous tecla==0 and the current tecla is exactly one-hot. Multi-bit or held keys are ignored.
- ESPERA (0), digito=1: key press sets d1, goes to DIGITO2.
- DIGITO2 (1), digito=2: key press sets d2, latches produto={d1,d2}, goes to PAGA.
- PAGA (2), digito=0: keys ignored.
  - Price is preco(produto) from the package table.
  - An accepted coin adds its value to credito in the same cycle it is seen.
  - When credito+coin >= price, go to LIBERA on the next edge.
- LIBERA (3): libera=1 for exactly this cycle; credito -= price; go to TROCO.
- TROCO (4): if credito>0, troco_valido=1 and troco=credito; credito cleared; go to ESPERA.
- Coins outside PAGA: moeda_rejeita=1; credito unchanged.
- Coin that would overflow CREDIT_W: rejected (moeda_rejeita=1); credito unchanged.
- Timer:
  - Cleared on any accepted key or coin and in ESPERA; otherwise increments.
  - At TIMEOUT_CYCLES-1 in DIGITO2: erro=1, go to ESPERA.
  - At TIMEOUT_CYCLES-1 in PAGA: erro=1, go to TROCO (refund).
- cancela:
  - In DIGITO2: go to ESPERA, no erro.
  - In PAGA: go to TROCO.
  - Coin and cancela in the same PAGA cycle: coin is accepted first, then refunded in the change.
- Coin completing payment and cancela in the same cycle: payment wins, go to LIBERA.
- Latency: final coin in cycle N gives libera in N+1 and troco_valido in N+2.
- Unused state codes 5..7: go to ESPERA.

Optional Feature:
- Macro: ESTOQUE_EN.
- Defined:
  - Sixteen 2-bit stock counters are initialised to INIT_STOCK on reset and decremented in LIBERA.
  - Selecting a product with stock 0 in DIGITO2 gives erro=1 and returns to ESPERA without entering PAGA.
- Undefined: no counters; stock is unlimited; erro only on timeout.

Decomposition:
- Package maquina_pkg holds:
  - state encoding localparams ESPERA..TROCO;
  - coin value function moeda_unidades(code);
  - 16-entry price table preco(id), with price = 2 + d1 + d2 units;
  - default widths.
- One sub-module, detector_tecla: registers tecla and emits a one-cycle press strobe plus a 2-bit digit for valid one-hot presses.

Test Plan:
- Keys 0010 then 0001 (released between), then coins 2,2 units (price of {1,0} = 3): produto=4'b0100; libera 1 cycle after the 2nd coin; troco_valido with troco=1 on the next cycle; back to ESPERA.
- Hold tecla=0100 for 10 cycles, plus tecla=0110: exactly one digit captured; 0110 ignored; digito stays 2.
- Coin in ESPERA: moeda_rejeita=1, credito=0. In PAGA with credito=60 (CREDIT_W=6), coin 8: rejected, credito stays 60.
- Enter PAGA, insert 1 unit, wait TIMEOUT_CYCLES: erro=1, troco=1, state ESPERA.
- In PAGA with credito=1, assert cancela and a 2-unit coin in the same cycle (price ≥4): troco=3.
- With ESTOQUE_EN, buy product 0 INIT_STOCK times; on the next selection of 0: erro=1 after d2, no PAGA, libera never asserted.
